// File: rtl/key_sender.sv
// rtl/key_sender.sv - transmits a stored digit code to a lock and reports the unlock outcome
//
// Purpose: holds a CODE_LEN-digit code in a shift register, strobes it out one
// digit at a time with GAP_CYCLES idle cycles after each strobe, then watches
// `locked` for up to TIMEOUT cycles and reports success or fail.
//
// Ports:
//   clk        - clock, rising edge active
//   reset_n    - asynchronous active-low reset
//   load       - shift load_digit into the code (ignored while busy)
//   load_digit - digit to store, 0-9 accepted
//   start      - begin an attempt (ignored while busy)
//   locked     - lock status, 0 = unlocked
//   key        - digit presented to the lock (0 outside a strobe)
//   key_valid  - one-cycle strobe qualifying key
//   busy       - high whenever an attempt is in progress
//   done       - one-cycle pulse at the end of an attempt
//   success    - last attempt unlocked, held until next start
//   fail       - last attempt timed out, held until next start
//   bad_digit  - one-cycle pulse when a load is rejected
module key_sender #(
  parameter int CODE_LEN   = 6,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       start,
  input  logic       locked,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic       success,
  output logic       fail,
  output logic       bad_digit
);

  // A zero timeout still gets one look at the lock.
  localparam int TO_EFF = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int CW = (TO_EFF > 1) ? $clog2(TO_EFF) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(CODE_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CHK_LAST = CW'(TO_EFF - 1);

  function automatic logic [CODE_LEN-1:0][3:0] default_code();
    logic [CODE_LEN-1:0][3:0] c;
    for (int i = 0; i < CODE_LEN; i++) begin
      case (i)
        0:       c[i] = 4'd3;
        1:       c[i] = 4'd3;
        2:       c[i] = 4'd5;
        3:       c[i] = 4'd2;
        4:       c[i] = 4'd5;
        5:       c[i] = 4'd6;
        default: c[i] = 4'd0;
      endcase
    end
    return c;
  endfunction

  localparam logic [CODE_LEN-1:0][3:0] DEFAULT_CODE = default_code();

  typedef enum logic [2:0] {IDLE, SEND, GAP, CHECK, DONE} state_t;

  state_t                     state;
  logic [CODE_LEN-1:0][3:0]   code;     // element 0 is sent first
  logic [CODE_LEN-1:0][3:0]   tx;       // working copy, shifted as digits go out
  logic [IW-1:0]              idx;
  logic [GW-1:0]              gap_cnt;
  logic [CW-1:0]              chk_cnt;

  logic [CODE_LEN:0][3:0]     code_ext;
  logic [CODE_LEN:0][3:0]     tx_ext;
  logic [CODE_LEN-1:0][3:0]   code_eff;
  logic [CODE_LEN-1:0][3:0]   tx_next;
  logic                       load_ok;
  logic                       advance;

  assign code_ext = {load_digit, code};
  assign tx_ext   = {4'd0, tx};
  assign tx_next  = tx_ext[CODE_LEN:1];
  assign load_ok  = load && (state == IDLE) && (load_digit <= 4'd9);
  // Code as it stands after this cycle's load, so a simultaneous start
  // transmits the freshly loaded digit.
  assign code_eff = load_ok ? code_ext[CODE_LEN:1] : code;
  // End of one digit slot: after SEND with no gap, or after the last gap cycle.
  assign advance  = ((state == SEND) && (GAP_CYCLES == 0)) ||
                    ((state == GAP) && (gap_cnt == GAP_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      code      <= DEFAULT_CODE;
      tx        <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      chk_cnt   <= '0;
      key       <= 4'd0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      success   <= 1'b0;
      fail      <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      key       <= 4'd0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      bad_digit <= 1'b0;

      if (state == IDLE && load) begin
        if (load_ok) code <= code_eff;
        else         bad_digit <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            busy      <= 1'b1;
            success   <= 1'b0;
            fail      <= 1'b0;
            idx       <= '0;
            tx        <= code_eff;
            key       <= code_eff[0];
            key_valid <= 1'b1;
          end
        end
        SEND: begin
          if (!advance) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (!advance) gap_cnt <= gap_cnt + GW'(1);
        end
        CHECK: begin
          if (!locked) begin
            state   <= DONE;
            success <= 1'b1;
            done    <= 1'b1;
          end else if (chk_cnt == CHK_LAST) begin
            state <= DONE;
            fail  <= 1'b1;
            done  <= 1'b1;
          end else begin
            chk_cnt <= chk_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (advance) begin
        idx <= idx + IW'(1);
        tx  <= tx_next;
        if (idx == IDX_LAST) begin
          state   <= CHECK;
          chk_cnt <= '0;
        end else begin
          state     <= SEND;
          key       <= tx_next[0];
          key_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/key_sender.md
KEY_SENDER -- requirements
Module: key_sender

Interface
REQ-001 The block SHALL provide parameter CODE_LEN, default 6, giving the number of digits in the stored code.
REQ-002 The block SHALL provide parameter GAP_CYCLES, default 2, giving the idle cycles inserted after each digit strobe.
REQ-003 The block SHALL provide parameter TIMEOUT, default 8, giving the maximum cycles spent waiting for unlock.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port load, input, 1 bit: write load_digit into code storage this cycle.
REQ-008 Port load_digit, input, 4 bits: digit to store; legal values are 0-9.
REQ-009 Port start, input, 1 bit: begin transmitting the stored code.
REQ-010 Port locked, input, 1 bit: lock status returned by the lock; 0 means unlocked.
REQ-011 Port key, output, 4 bits: digit presented to the lock.
REQ-012 Port key_valid, output, 1 bit: one-cycle strobe qualifying key.
REQ-013 Port busy, output, 1 bit: high while not in IDLE.
REQ-014 Port done, output, 1 bit: one-cycle pulse when an attempt ends.
REQ-015 Port success, output, 1 bit: the last attempt unlocked; held until the next start.
REQ-016 Port fail, output, 1 bit: the last attempt timed out; held until the next start.
REQ-017 Port bad_digit, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-018 Code storage SHALL be a CODE_LEN x 4-bit shift register whose default contents are 3,3,5,2,5,6, with digit0 = 3 sent first.
REQ-019 An accepted load SHALL shift the register, dropping digit0, and place load_digit in position CODE_LEN-1; N consecutive loads d0..dN-1 with N = CODE_LEN therefore yield code d0..dN-1.
REQ-020 A load with load_digit > 9 SHALL leave the code unchanged and pulse bad_digit the following cycle.
REQ-021 A load while busy=1 SHALL be ignored, with no bad_digit pulse.
REQ-022 The FSM SHALL have the states IDLE, SEND, GAP, CHECK and DONE.
REQ-023 IDLE -> SEND SHALL occur at the edge sampling start=1; at that edge success and fail SHALL clear and the digit index SHALL be set to 0.
REQ-024 A start while busy=1 SHALL be ignored.
REQ-025 SEND SHALL last exactly 1 cycle, with key_valid=1 and key equal to the indexed digit.
REQ-026 SEND SHALL be followed by GAP when GAP_CYCLES > 0; otherwise it SHALL be followed by the next SEND or by CHECK.
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles, with key_valid=0 and key=0.
REQ-028 At the end of GAP the index SHALL increment; the FSM SHALL go to SEND if the index is below CODE_LEN, else to CHECK.
REQ-029 Digit i's strobe SHALL occur in cycle 1 + i*(1+GAP_CYCLES) after the start edge.
REQ-030 Outside SEND, key SHALL be 0 and key_valid SHALL be 0.
REQ-031 In CHECK, locked SHALL be sampled every cycle; the first sample of 0 SHALL cause a transition to DONE with success=1.
REQ-032 If TIMEOUT consecutive CHECK samples are all 1, the FSM SHALL go to DONE with fail=1.
REQ-033 The CHECK counter SHALL be wide enough for TIMEOUT; TIMEOUT=0 SHALL be treated as 1.
REQ-034 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-035 success and fail SHALL never be 1 simultaneously.
REQ-036 busy SHALL be 1 in SEND, GAP, CHECK and DONE, and 0 in IDLE.
REQ-037 When load and start are sampled in the same IDLE cycle, the load SHALL take effect first and the transmitted code SHALL include the new digit.
REQ-038 A locked=0 sample outside CHECK SHALL have no effect.

Reset
REQ-039 reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE with key=0, key_valid=0, busy=0, done=0, success=0, fail=0 and bad_digit=0.
REQ-040 reset_n=0 SHALL immediately restore the code to 3,3,5,2,5,6 and clear all counters.
REQ-041 A reset asserted mid-attempt SHALL abort the attempt with no done pulse.
REQ-042 After reset_n rises, the first active edge SHALL operate normally.

Verification
REQ-043 Defaults, then start with locked held at 1: key_valid pulses at cycles 1,4,7,10,13,16 with key=3,3,5,2,5,6; after 8 CHECK cycles, done=1 and fail=1 together, success=0.
REQ-044 Load 1,2,3,4,5,6, then start; locked drops to 0 on the 3rd CHECK cycle: the sequence is 1..6, then done=1 and success=1 on the next cycle, busy=0 after.
REQ-045 Load 4'hA: bad_digit pulses and the code is unchanged (transmits 3,3,5,2,5,6); a load of 7 and a start during SEND are both ignored.
REQ-046 reset_n pulsed low during the 3rd GAP: key_valid=0 and busy=0 asynchronously, no done pulse, and the next attempt sends 3,3,5,2,5,6.
REQ-047 GAP_CYCLES=0, CODE_LEN=4: key_valid is high for 4 consecutive cycles starting at cycle 1; a loaded start issued in the same cycle includes the new digit last.
